// File: rtl/triangle_stream_fifo.sv
// triangle_stream_fifo
// Back-pressured queue of triangles between triangle setup and the rasteriser.
// The queue has DEPTH array entries and a registered show-ahead output stage.
// 'count' covers everything held: the unread array entries plus the output register.
//
// Handshake rules (both sides):
//  - A beat transfers on a rising edge where valid && ready.
//  - Producer side: in_ready does not depend on in_valid.
//  - Consumer side: out_valid/out_data are registered. They hold while out_ready is low.
module triangle_stream_fifo #(
    parameter int WI        = 8,
    parameter int WF        = 8,
    parameter int NUM_COORD = 9,
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 12
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [(WI+WF)*NUM_COORD-1:0]   in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [(WI+WF)*NUM_COORD-1:0]   out_data,
    output logic [ADDR_W:0]                count,
    output logic                           almost_full,
    output logic                           overflow
);

    localparam int              DW      = (WI + WF) * NUM_COORD;
    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_THRESH);

    logic [DW-1:0]     mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              accept;
    logic              pop;
    logic              load;
    logic [ADDR_W:0]   arr_cnt;
    logic [ADDR_W:0]   count_next;

    // Handshake decode, array occupancy and next count.
    // The output stage only loads from entries already in the array before the edge.
    // There is no same-edge bypass from in_data to out_data.
    always_comb begin
        in_ready   = !flush && (count != DEPTH_C);
        accept     = in_valid && in_ready;
        pop        = out_valid && out_ready && !flush;
        arr_cnt    = count - {{ADDR_W{1'b0}}, out_valid};
        load       = !flush && (arr_cnt != '0) && (!out_valid || pop);
        count_next = count;
        if (accept && !pop) begin
            count_next = count + (ADDR_W + 1)'(1);
        end else if (pop && !accept) begin
            count_next = count - (ADDR_W + 1)'(1);
        end
    end

    // Payload storage. The array is left unreset because its contents are
    // ignored until they are written.
    always_ff @(posedge Clk) begin
        if (accept) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers, output stage, count and flags.
    // Flush clears all of these except out_data.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_valid   <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
            if (accept) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (load) begin
                rd_ptr    <= rd_ptr + ADDR_W'(1);
                out_data  <= mem[rd_ptr];
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
            count       <= count_next;
            almost_full <= (count_next >= AF_C);
        end
    end

endmodule

// File: tb/tb_triangle_stream_fifo.sv
// Self-checking bench for triangle_stream_fifo.
// The reference model holds the array as a queue, plus a separate output-register
// slot that follows the show-ahead load/pop rules.
module tb_triangle_stream_fifo;

    localparam int DW    = 144;
    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [4:0]    count;
    logic          almost_full;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] arr_q[$];
    logic          m_ov;
    logic [DW-1:0] m_od;
    logic          m_ovf;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];

    triangle_stream_fifo dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .almost_full (almost_full),
        .overflow    (overflow)
    );

    // Clock and watchdog
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] mk(input int idx);
        logic [15:0] w;
        w = 16'(idx);
        return {9{w}};
    endfunction

    function automatic int m_count();
        return arr_q.size() + (m_ov ? 1 : 0);
    endfunction

    task automatic model_reset();
        arr_q.delete();
        m_ov  = 1'b0;
        m_od  = '0;
        m_ovf = 1'b0;
    endtask

    // Advance one clock edge. The model consumes the inputs held across the edge.
    // Outputs are then sampled 1 time unit after the edge.
    task automatic cycle();
        int  n;
        logic rdy, acc, pp, ld;
        n   = m_count();
        rdy = !flush && (n != DEPTH);
        if (flush) begin
            arr_q.delete();
            m_ov  = 1'b0;
            m_ovf = 1'b0;
        end else begin
            acc = in_valid && rdy;
            pp  = m_ov && out_ready;
            ld  = (arr_q.size() > 0) && (!m_ov || pp);
            if (in_valid && !rdy) m_ovf = 1'b1;
            if (ld) begin
                m_od = arr_q.pop_front();
                m_ov = 1'b1;
            end else if (pp) begin
                m_ov = 1'b0;
            end
            if (acc) arr_q.push_back(in_data);
        end
        @(posedge Clk);
        #1;
    endtask

    // Pop everything the model holds and record what the consumer saw.
    task automatic drain(input int budget);
        got_q.delete();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < budget && m_count() > 0; k++) begin
            if (out_valid) got_q.push_back(out_data);
            cycle();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        model_reset();
        #1;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (almost_full !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_flags: af=%b ovf=%b want 0 0", almost_full, overflow); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = mk(i);
            cycle();
            checks++; if (count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
            checks++; if (almost_full !== (i + 1 >= AF)) begin errors++; $display("FAIL fill_af[%0d]: got %b want %b", i, almost_full, (i + 1 >= AF)); end
            checks++; if (in_ready !== (i + 1 < DEPTH)) begin errors++; $display("FAIL fill_in_ready[%0d]: got %b want %b", i, in_ready, (i + 1 < DEPTH)); end
            checks++; if (out_valid !== (i >= 1)) begin errors++; $display("FAIL fill_out_valid[%0d]: got %b want %b", i, out_valid, (i >= 1)); end
            if (i >= 1) begin
                checks++; if (out_data !== mk(0)) begin errors++; $display("FAIL fill_out_data[%0d]: got %h want %h", i, out_data, mk(0)); end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_overflow();
        in_valid = 1'b1;
        in_data  = mk(999);
        cycle();
        in_valid = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d want 16", count); end
        cycle();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        checks++; if (count !== 5'd15 || in_ready !== 1'b1) begin errors++; $display("FAIL ovf_pop: count=%0d in_ready=%b want 15 1", count, in_ready); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_after_pop: got %b want 1", overflow); end
        checks++; if (out_data !== mk(1) || out_valid !== 1'b1) begin errors++; $display("FAIL ovf_head: got %h/%b want %h/1", out_data, out_valid, mk(1)); end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        repeat (8) cycle();
        out_ready = 1'b0;
        checks++; if (count !== 5'd7 || overflow !== 1'b1) begin errors++; $display("FAIL flush_pre: count=%0d ovf=%b want 7 1", count, overflow); end
        checks++; if (out_data !== mk(9)) begin errors++; $display("FAIL flush_pre_head: got %h want %h", out_data, mk(9)); end
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = mk(500);
        out_ready = 1'b1;
        cycle();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL flush_flags: ov=%b ovf=%b want 0 0", out_valid, overflow); end
        checks++; if (in_ready !== 1'b1 || almost_full !== 1'b0) begin errors++; $display("FAIL flush_ready: rdy=%b af=%b want 1 0", in_ready, almost_full); end
        cycle();
        checks++; if (out_valid !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL flush_no_accept: ov=%b count=%0d want 0 0", out_valid, count); end
    endtask

    task automatic test_stream();
        int sent, recv, k;
        sent = 0; recv = 0; k = 0;
        exp_q.delete();
        while (recv < 40 && k < 3000) begin
            in_valid  = (sent < 40) && ($urandom_range(0, 3) != 0);
            in_data   = mk(100 + sent);
            out_ready = $urandom_range(0, 1) != 0;
            checks++; if (in_ready !== (m_count() != DEPTH)) begin errors++; $display("FAIL stream_in_ready: got %b want %b", in_ready, (m_count() != DEPTH)); end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0 || out_data !== exp_q[0]) begin
                    errors++; $display("FAIL stream_data[%0d]: got %h want %h", recv, out_data, (exp_q.size() > 0) ? exp_q[0] : '0);
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                recv++;
            end
            cycle();
            checks++; if (count !== 5'(m_count()) || out_valid !== m_ov) begin errors++; $display("FAIL stream_state: count=%0d ov=%b want %0d %b", count, out_valid, m_count(), m_ov); end
            checks++; if (almost_full !== (m_count() >= AF)) begin errors++; $display("FAIL stream_af: got %b want %b", almost_full, (m_count() >= AF)); end
            k++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (recv !== 40) begin errors++; $display("FAIL stream_total: got %0d want 40", recv); end
        checks++; if (count !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL stream_empty: count=%0d ov=%b want 0 0", count, out_valid); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = mk(200 + i);
            cycle();
        end
        in_valid = 1'b0;
        checks++; if (count !== 5'd5 || out_data !== mk(200)) begin errors++; $display("FAIL simul_pre: count=%0d head=%h want 5 %h", count, out_data, mk(200)); end
        in_valid  = 1'b1;
        in_data   = mk(205);
        out_ready = 1'b1;
        cycle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (count !== 5'd5) begin errors++; $display("FAIL simul_count: got %0d want 5", count); end
        checks++; if (out_valid !== 1'b1 || out_data !== mk(201)) begin errors++; $display("FAIL simul_head: got %h/%b want %h/1", out_data, out_valid, mk(201)); end
        drain(50);
        checks++; if (got_q.size() != 5) begin errors++; $display("FAIL simul_drain_len: got %0d want 5", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 5; i++) begin
            checks++; if (got_q[i] !== mk(201 + i)) begin errors++; $display("FAIL simul_drain[%0d]: got %h want %h", i, got_q[i], mk(201 + i)); end
        end
    endtask

    task automatic test_back_to_back();
        int pops;
        pops = 0;
        in_valid = 1'b1;
        in_data  = mk(300);
        cycle();
        in_valid = 1'b0;
        cycle();
        checks++; if (out_valid !== 1'b1 || count !== 5'd1) begin errors++; $display("FAIL b2b_pre: ov=%b count=%0d want 1 1", out_valid, count); end
        in_valid  = 1'b1;
        in_data   = mk(301);
        out_ready = 1'b1;
        cycle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || count !== 5'd1) begin errors++; $display("FAIL b2b_bubble: ov=%b count=%0d want 0 1", out_valid, count); end
        cycle();
        checks++; if (out_valid !== 1'b1 || out_data !== mk(301)) begin errors++; $display("FAIL b2b_reload: got %h/%b want %h/1", out_data, out_valid, mk(301)); end
        for (int i = 0; i < 30; i++) begin
            in_valid  = 1'b1;
            in_data   = mk(310 + i);
            out_ready = 1'b1;
            if (out_valid) begin
                checks++; if (out_data !== m_od) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, out_data, m_od); end
                if (i >= 10) pops++;
            end
            cycle();
            checks++; if (count !== 5'(m_count())) begin errors++; $display("FAIL b2b_count[%0d]: got %0d want %0d", i, count, m_count()); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (pops !== 20) begin errors++; $display("FAIL b2b_throughput: got %0d pops want 20", pops); end
        drain(50);
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL b2b_drained: got %0d want 0", count); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1;
            in_data  = mk(350 + i);
            cycle();
        end
        checks++; if (almost_full !== 1'b1 || count !== 5'd13) begin errors++; $display("FAIL areset_pre: af=%b count=%0d want 1 13", almost_full, count); end
        #3;
        Reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || count !== 5'd0 || almost_full !== 1'b0) begin errors++; $display("FAIL areset_async: ov=%b count=%0d af=%b want 0 0 0", out_valid, count, almost_full); end
        @(posedge Clk);
        #1;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL areset_held: got %0d want 0", count); end
        @(negedge Clk);
        in_valid = 1'b0;
        Reset_n  = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = mk(400 + i);
            cycle();
        end
        in_valid = 1'b0;
        checks++; if (count !== 5'd4) begin errors++; $display("FAIL areset_refill: got %0d want 4", count); end
        drain(50);
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL areset_drain_len: got %0d want 4", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            checks++; if (got_q[i] !== mk(400 + i)) begin errors++; $display("FAIL areset_drain[%0d]: got %h want %h", i, got_q[i], mk(400 + i)); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_overflow();
        test_flush();
        test_stream();
        test_simultaneous();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
